// File: rtl/spi_xfer_sequencer.sv
// ---------------------------------------------------------------------------
// spi_xfer_sequencer: burst master for the 8-bit SPI core register port. Rev 1.0
// ---------------------------------------------------------------------------
`timescale 1ns/1ps
`default_nettype none

module spi_xfer_sequencer #(
  parameter int MAX_LEN = 16,
  parameter int LEN_W   = 5,
  parameter int TIMEOUT = 1023
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             cmd_valid,
  input  logic [LEN_W-1:0] cmd_len,
  output logic             cmd_ready,
  input  logic [7:0]       tx_data,
  input  logic             tx_valid,
  output logic             tx_ready,
  output logic [7:0]       rx_data,
  output logic             rx_valid,
  input  logic             rx_ready,
  output logic             busy,
  output logic             done,
  output logic             err,
  output logic             spi_select,
  output logic [2:0]       mem_addr,
  output logic             read_n,
  output logic             write_n,
  output logic [15:0]      data_from_cpu,
  input  logic [15:0]      data_to_cpu,
  input  logic             readyfordata,
  input  logic             dataavailable
);

  localparam int               TO_W    = $clog2(TIMEOUT + 1);
  localparam logic [TO_W-1:0]  TO_MAX  = TO_W'(TIMEOUT);
  localparam logic [LEN_W-1:0] LEN_MAX = LEN_W'(MAX_LEN);

  typedef enum logic [3:0] {
    IDLE    = 4'd0,
    CLR_ST  = 4'd1,
    SSO_ON  = 4'd2,
    WAIT_TX = 4'd3,
    WR_TX   = 4'd4,
    WAIT_RX = 4'd5,
    RD_RX   = 4'd6,
    PUSH    = 4'd7,
    SSO_OFF = 4'd8
  } state_t;

  state_t           state, state_nxt;
  logic [1:0]       phase, phase_nxt;
  logic [LEN_W-1:0] count, count_nxt;
  logic [TO_W-1:0]  tmo, tmo_nxt;
  logic [7:0]       tx_byte, tx_byte_nxt;
  logic [7:0]       rx_byte, rx_byte_nxt;
  logic             done_q, done_nxt;
  logic             err_q, err_nxt;

  logic bus_state;
  logic bus_last;
  logic strobe_on;
  logic wait_state;
  logic unused_hi;

  // Bus op: phases 0 and 1 hold the strobe, phase 2 is the mandatory idle cycle.
  assign bus_state  = (state == CLR_ST) || (state == SSO_ON) || (state == WR_TX) ||
                      (state == RD_RX)  || (state == SSO_OFF);
  assign strobe_on  = bus_state && (phase != 2'd2);
  assign bus_last   = bus_state && (phase == 2'd2);
  assign wait_state = (state == WAIT_TX) || (state == WAIT_RX);
  assign unused_hi  = ^data_to_cpu[15:8];

  assign rx_data = rx_byte;
  assign done    = done_q;
  assign err     = err_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      state   <= IDLE;
      phase   <= 2'd0;
      count   <= '0;
      tmo     <= '0;
      tx_byte <= 8'h00;
      rx_byte <= 8'h00;
      done_q  <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state   <= state_nxt;
      phase   <= phase_nxt;
      count   <= count_nxt;
      tmo     <= tmo_nxt;
      tx_byte <= tx_byte_nxt;
      rx_byte <= rx_byte_nxt;
      done_q  <= done_nxt;
      err_q   <= err_nxt;
    end
  end

  always_comb begin
    state_nxt     = state;
    phase_nxt     = phase;
    count_nxt     = count;
    tmo_nxt       = '0;
    tx_byte_nxt   = tx_byte;
    rx_byte_nxt   = rx_byte;
    done_nxt      = 1'b0;
    err_nxt       = err_q;
    cmd_ready     = (state == IDLE);
    busy          = (state != IDLE);
    tx_ready      = 1'b0;
    rx_valid      = (state == PUSH);
    mem_addr      = 3'd0;
    data_from_cpu = 16'h0000;

    if (bus_state) begin
      phase_nxt = bus_last ? 2'd0 : phase + 2'd1;
    end
    // Counter is held at zero outside the wait states, so it restarts on every entry.
    if (wait_state) begin
      tmo_nxt = (tmo == TO_MAX) ? tmo : tmo + TO_W'(1);
    end

    case (state)
      IDLE: begin
        if (cmd_valid) begin
          err_nxt   = 1'b0;
          count_nxt = (cmd_len > LEN_MAX) ? LEN_MAX : cmd_len;
          if (cmd_len == '0) begin
            done_nxt = 1'b1;
          end else begin
            state_nxt = CLR_ST;
            phase_nxt = 2'd0;
          end
        end
      end
      CLR_ST: begin
        mem_addr = 3'd2;
        if (bus_last) state_nxt = SSO_ON;
      end
      SSO_ON: begin
        mem_addr      = 3'd3;
        data_from_cpu = 16'h0400;
        if (bus_last) state_nxt = WAIT_TX;
      end
      WAIT_TX: begin
        if (readyfordata && tx_valid) begin
          tx_ready    = 1'b1;
          tx_byte_nxt = tx_data;
          state_nxt   = WR_TX;
        end else if (!readyfordata && (tmo == TO_MAX)) begin
          err_nxt   = 1'b1;
          state_nxt = SSO_OFF;
        end
      end
      WR_TX: begin
        mem_addr      = 3'd1;
        data_from_cpu = {8'h00, tx_byte};
        if (bus_last) state_nxt = WAIT_RX;
      end
      WAIT_RX: begin
        if (dataavailable) begin
          state_nxt = RD_RX;
        end else if (tmo == TO_MAX) begin
          err_nxt   = 1'b1;
          state_nxt = SSO_OFF;
        end
      end
      RD_RX: begin
        mem_addr = 3'd0;
        // The core registers its read data, so it is valid in the second strobe cycle.
        if (phase == 2'd1) rx_byte_nxt = data_to_cpu[7:0];
        if (bus_last) state_nxt = PUSH;
      end
      PUSH: begin
        if (rx_ready) begin
          count_nxt = count - LEN_W'(1);
          state_nxt = (count <= LEN_W'(1)) ? SSO_OFF : WAIT_TX;
        end
      end
      SSO_OFF: begin
        mem_addr = 3'd3;
        if (bus_last) begin
          done_nxt  = 1'b1;
          state_nxt = IDLE;
        end
      end
      default: begin
        state_nxt = IDLE;
        phase_nxt = 2'd0;
      end
    endcase

    spi_select = strobe_on;
    write_n    = !(strobe_on && (state != RD_RX));
    read_n     = !(strobe_on && (state == RD_RX));
  end

endmodule

`default_nettype wire
